// File: rtl/rx8b10b_pkg.sv
// Shared definitions for the 8b/10b receive path.
//
// Contents:
//   SYM_W, PHASE_W, CNT_W - widths of symbols, phase counter and comma counters
//   PHASE_MAX             - last phase value before wrapping to 0
//   COMMA_NEG / COMMA_POS - K28.5 in window bit order (bit0 = first bit 'a')
//   align_state_t         - comma aligner state encoding
//   next_phase()          - modulo-10 phase increment
package rx8b10b_pkg;

    localparam int SYM_W   = 10;
    localparam int PHASE_W = 4;
    localparam int CNT_W   = 4;

    localparam logic [PHASE_W-1:0] PHASE_MAX = 4'd9;

    // K28.5, running disparity negative and positive (bitwise complements).
    localparam logic [SYM_W-1:0] COMMA_NEG = 10'h17C;
    localparam logic [SYM_W-1:0] COMMA_POS = 10'h283;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } align_state_t;

    // Phase counts 0..PHASE_MAX and wraps to 0.
    function automatic logic [PHASE_W-1:0] next_phase(input logic [PHASE_W-1:0] p);
        return (p == PHASE_MAX) ? '0 : p + 4'd1;
    endfunction

endpackage

// File: rtl/comma_match.sv
// Combinational K28.5 detector for the 10-bit deserializer window.
//
// Ports:
//   window - current shift-register contents (bit0 = oldest bit)
//   match  - high when window equals either disparity of the comma
module comma_match
    import rx8b10b_pkg::*;
#(
    parameter logic [SYM_W-1:0] NEG_WORD = COMMA_NEG,
    parameter logic [SYM_W-1:0] POS_WORD = COMMA_POS
) (
    input  logic [SYM_W-1:0] window,
    output logic             match
);

    localparam int N_PAT = 2;
    localparam logic [N_PAT-1:0][SYM_W-1:0] PATTERNS = {POS_WORD, NEG_WORD};

    logic [N_PAT-1:0] hit;

    for (genvar gi = 0; gi < N_PAT; gi++) begin : g_pattern
        assign hit[gi] = (window == PATTERNS[gi]);
    end

    assign match = |hit;

endmodule

// File: rtl/comma_aligner.sv
// K28.5 comma aligner: watches the sliding 10-bit deserializer window,
// establishes the symbol boundary, acquires/maintains lock and emits one
// aligned symbol with a valid strobe every 10 clocks.
//
// Ports:
//   clk          - system clock, one serial bit per cycle
//   reset        - asynchronous active-high reset, clears all state
//   align_en     - alignment enable; low forces HUNT
//   sipo_data    - shift-register window, new value every clock
//   symbol_out   - aligned symbol (registered)
//   symbol_valid - one-cycle strobe qualifying symbol_out
//   locked       - high while in LOCKED
//   comma_det    - one-cycle pulse: comma in window this cycle (any phase/state)
//   align_err    - one-cycle pulse: misaligned comma while LOCKED
module comma_aligner
    import rx8b10b_pkg::SYM_W, rx8b10b_pkg::PHASE_W, rx8b10b_pkg::CNT_W,
           rx8b10b_pkg::align_state_t, rx8b10b_pkg::HUNT, rx8b10b_pkg::ACQUIRE,
           rx8b10b_pkg::LOCKED, rx8b10b_pkg::next_phase;
#(
    parameter logic [SYM_W-1:0] COMMA_NEG     = rx8b10b_pkg::COMMA_NEG,
    parameter logic [SYM_W-1:0] COMMA_POS     = rx8b10b_pkg::COMMA_POS,
    parameter int unsigned      LOCK_COMMAS   = 3,
    parameter int unsigned      UNLOCK_COMMAS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             align_en,
    input  logic [SYM_W-1:0] sipo_data,
    output logic [SYM_W-1:0] symbol_out,
    output logic             symbol_valid,
    output logic             locked,
    output logic             comma_det,
    output logic             align_err
);

    localparam logic [CNT_W-1:0] LOCK_LIM   = CNT_W'(LOCK_COMMAS);
    localparam logic [CNT_W-1:0] UNLOCK_LIM = CNT_W'(UNLOCK_COMMAS);
    localparam bit               LOCK_ON_FIRST = (LOCK_COMMAS <= 1);

    align_state_t       state_reg;
    logic [PHASE_W-1:0] phase_reg;
    logic [CNT_W-1:0]   good_cnt_reg;
    logic [CNT_W-1:0]   bad_cnt_reg;

    logic               match;
    logic               at_boundary;
    logic               restart;
    logic [CNT_W-1:0]   good_cnt_next;
    logic [CNT_W-1:0]   bad_cnt_next;

    comma_match #(
        .NEG_WORD (COMMA_NEG),
        .POS_WORD (COMMA_POS)
    ) u_comma_match (
        .window (sipo_data),
        .match  (match)
    );

    always_comb begin
        // phase_reg==0 means 10 clocks have passed since the last symbol.
        at_boundary   = (phase_reg == '0);

        // Saturating increments of the comma counters.
        good_cnt_next = (good_cnt_reg >= LOCK_LIM)   ? good_cnt_reg : good_cnt_reg + 4'd1;
        bad_cnt_next  = (bad_cnt_reg  >= UNLOCK_LIM) ? bad_cnt_reg  : bad_cnt_reg  + 4'd1;

        // A comma that (re)defines the symbol boundary: any comma in HUNT,
        // an off-boundary comma in ACQUIRE, or the off-boundary comma that
        // exhausts the LOCKED tolerance. The unlocking comma is taken as the
        // new alignment straight away, so HUNT is passed through within the
        // same edge and that comma is emitted as the first symbol.
        restart = 1'b0;
        if (match) begin
            unique case (state_reg)
                HUNT:    restart = 1'b1;
                ACQUIRE: restart = !at_boundary;
                LOCKED:  restart = !at_boundary && (bad_cnt_next >= UNLOCK_LIM);
                default: restart = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= HUNT;
            phase_reg    <= '0;
            good_cnt_reg <= '0;
            bad_cnt_reg  <= '0;
            symbol_out   <= '0;
            symbol_valid <= 1'b0;
            locked       <= 1'b0;
            comma_det    <= 1'b0;
            align_err    <= 1'b0;
        end else begin
            // Detection is reported regardless of state or enable.
            comma_det    <= match;
            symbol_valid <= 1'b0;
            align_err    <= 1'b0;

            if (!align_en) begin
                // Disable wins over any comma seen on this edge.
                state_reg    <= HUNT;
                locked       <= 1'b0;
                phase_reg    <= '0;
                good_cnt_reg <= '0;
                bad_cnt_reg  <= '0;
            end else if (restart) begin
                phase_reg    <= 4'd1;
                good_cnt_reg <= 4'd1;
                bad_cnt_reg  <= '0;
                symbol_out   <= sipo_data;
                symbol_valid <= 1'b1;
                align_err    <= (state_reg == LOCKED);
                if (LOCK_ON_FIRST) begin
                    state_reg <= LOCKED;
                    locked    <= 1'b1;
                end else begin
                    state_reg <= ACQUIRE;
                    locked    <= 1'b0;
                end
            end else begin
                unique case (state_reg)
                    ACQUIRE: begin
                        phase_reg <= next_phase(phase_reg);
                        if (at_boundary) begin
                            symbol_out   <= sipo_data;
                            symbol_valid <= 1'b1;
                        end
                        // Off-boundary commas restart, so any match here is aligned.
                        if (match) begin
                            good_cnt_reg <= good_cnt_next;
                            if (good_cnt_next >= LOCK_LIM) begin
                                state_reg <= LOCKED;
                                locked    <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        // Output phase is held through tolerated misaligned commas.
                        phase_reg <= next_phase(phase_reg);
                        if (at_boundary) begin
                            symbol_out   <= sipo_data;
                            symbol_valid <= 1'b1;
                        end
                        if (match) begin
                            if (at_boundary) begin
                                bad_cnt_reg <= '0;
                            end else begin
                                align_err   <= 1'b1;
                                bad_cnt_reg <= bad_cnt_next;
                            end
                        end
                    end
                    default: begin
                        // HUNT without a comma, or an unused encoding.
                        state_reg <= HUNT;
                        locked    <= 1'b0;
                        phase_reg <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_comma_aligner.sv
module tb_comma_aligner;

    localparam int LOCK   = 3;
    localparam int UNLOCK = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       align_en;
    logic [9:0] sipo_data;
    logic [9:0] symbol_out;
    logic       symbol_valid;
    logic       locked;
    logic       comma_det;
    logic       align_err;

    always #5 clk = ~clk;

    comma_aligner #(
        .LOCK_COMMAS   (LOCK),
        .UNLOCK_COMMAS (UNLOCK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .align_en     (align_en),
        .sipo_data    (sipo_data),
        .symbol_out   (symbol_out),
        .symbol_valid (symbol_valid),
        .locked       (locked),
        .comma_det    (comma_det),
        .align_err    (align_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Serial line emulation: the window the deserializer would present.
    logic [9:0] win;
    bit         pol;          // next comma disparity: 0 -> 17C, 1 -> 283
    int         cyc;

    // Observed pulse tallies for directed checks.
    int valid_cnt, err_cnt, det_cnt;

    // Reference model: alignment tracked as "cycles since the comma that
    // defined the boundary"; a boundary is every multiple of 10 after it.
    int         m_mode;       // 0 hunt, 1 acquire, 2 locked
    int         m_age;
    int         m_good;
    int         m_bad;
    logic [9:0] m_sym;
    logic       m_valid, m_locked, m_det, m_err;

    function automatic bit is_comma(input logic [9:0] w);
        return (w == 10'h17C) || (w == 10'h283);
    endfunction

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_good = 0; m_bad = 0;
        m_sym = '0; m_valid = 0; m_locked = 0; m_det = 0; m_err = 0;
    endtask

    task automatic model_take(input logic [9:0] w);
        m_age   = 0;
        m_good  = 1;
        m_bad   = 0;
        m_sym   = w;
        m_valid = 1;
        m_mode  = (LOCK == 1) ? 2 : 1;
    endtask

    task automatic model_edge(input logic en, input logic [9:0] w);
        bit on_grid;
        m_det   = is_comma(w);
        m_valid = 0;
        m_err   = 0;
        if (!en) begin
            m_mode = 0; m_good = 0; m_bad = 0; m_age = 0;
        end else if (m_mode == 0) begin
            if (m_det) model_take(w);
        end else begin
            m_age++;
            on_grid = (m_age % 10 == 0);
            if (on_grid) begin
                m_sym   = w;
                m_valid = 1;
            end
            if (m_det) begin
                if (m_mode == 1) begin
                    if (on_grid) begin
                        if (m_good < LOCK) m_good++;
                        if (m_good >= LOCK) m_mode = 2;
                    end else begin
                        model_take(w);
                    end
                end else begin
                    if (on_grid) begin
                        m_bad = 0;
                    end else begin
                        m_err = 1;
                        m_bad++;
                        if (m_bad >= UNLOCK) model_take(w);
                    end
                end
            end
        end
        m_locked = (m_mode == 2);
    endtask

    // One clock: inputs already driven; sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        model_edge(align_en, sipo_data);
        check("symbol_out",   symbol_out,   m_sym);
        check("symbol_valid", symbol_valid, m_valid);
        check("locked",       locked,       m_locked);
        check("comma_det",    comma_det,    m_det);
        check("align_err",    align_err,    m_err);
        if (symbol_valid) valid_cnt++;
        if (align_err)    err_cnt++;
        if (comma_det)    det_cnt++;
        $display("cyc=%0d en=%0b win=%h -> sym=%h v=%0b lock=%0b det=%0b err=%0b",
                 cyc, align_en, sipo_data, symbol_out, symbol_valid, locked, comma_det, align_err);
    endtask

    // Shift one bit in; with guard set, a bit that would form an
    // unintended comma is inverted.
    task automatic shift_bit(input logic b, input bit guard);
        logic [9:0] nw;
        nw = {b, win[9:1]};
        if (guard && is_comma(nw)) nw[9] = ~nw[9];
        win       = nw;
        sipo_data = win;
        step();
    endtask

    task automatic send_range(input logic [9:0] s, input int lo, input int hi, input bit guard);
        for (int i = lo; i <= hi; i++) shift_bit(s[i], guard);
    endtask

    task automatic send_random(input int nbits);
        for (int i = 0; i < nbits; i++) shift_bit(1'($urandom_range(0, 1)), 1'b1);
    endtask

    function automatic logic [9:0] next_comma();
        logic [9:0] c;
        c   = pol ? 10'h283 : 10'h17C;
        pol = ~pol;
        return c;
    endfunction

    // A zero guard symbol precedes each comma so no partial window
    // matches while the comma shifts in; the comma lands 20 bits later.
    task automatic send_comma();
        logic [9:0] c;
        c = next_comma();
        send_range(10'h000, 0, 9, 1'b1);
        send_range(c, 0, 9, 1'b0);
    endtask

    initial begin
        logic [9:0] c;
        cyc = 0; pol = 0; win = '0;
        valid_cnt = 0; err_cnt = 0; det_cnt = 0;
        reset = 1'b1; align_en = 1'b1; sipo_data = '0;
        model_reset();

        // 1: reset state, first comma, next boundary
        repeat (2) @(posedge clk);
        #1;
        check("rst_symbol_out",   symbol_out,   10'h000);
        check("rst_symbol_valid", symbol_valid, 10'h000);
        check("rst_locked",       locked,       10'h000);
        check("rst_comma_det",    comma_det,    10'h000);
        check("rst_align_err",    align_err,    10'h000);
        reset = 1'b0;

        send_random(20);
        send_comma();
        check("s1_det",   comma_det,    10'h001);
        check("s1_valid", symbol_valid, 10'h001);
        check("s1_sym",   symbol_out,   10'h17C);
        send_random(10);
        check("s1_next_valid", symbol_valid, 10'h001);
        check("s1_unlocked",   locked,       10'h000);

        // 2: two more aligned commas lock
        send_comma();
        check("s2_not_yet", locked, 10'h000);
        send_comma();
        check("s2_locked", locked, 10'h001);
        send_random(20);

        // 3: two misaligned commas (3 bits off) unlock
        err_cnt = 0;
        send_random(3);
        send_comma();
        check("s3_err1",       align_err, 10'h001);
        check("s3_still_lock", locked,    10'h001);
        send_comma();
        check("s3_unlock",  locked,       10'h000);
        check("s3_emit",    symbol_valid, 10'h001);
        check("s3_err_cnt", 10'(err_cnt), 10'd2);

        // 4: off-boundary comma during ACQUIRE realigns
        send_comma();
        check("s4_acq2", locked, 10'h000);
        send_random(4);
        send_comma();
        check("s4_realign_valid", symbol_valid, 10'h001);
        check("s4_realign_nolock", locked,      10'h000);
        send_comma();
        check("s4_good2", locked, 10'h000);
        send_comma();
        check("s4_locked", locked, 10'h001);

        // 5: asynchronous reset between edges
        #2;
        reset = 1'b1; win = '0; sipo_data = '0;
        #1;
        check("s5_symbol_out",   symbol_out,   10'h000);
        check("s5_symbol_valid", symbol_valid, 10'h000);
        check("s5_locked",       locked,       10'h000);
        check("s5_comma_det",    comma_det,    10'h000);
        check("s5_align_err",    align_err,    10'h000);
        #1;
        reset = 1'b0;
        model_reset();
        valid_cnt = 0;
        send_random(30);
        check("s5_no_valid", 10'(valid_cnt), 10'd0);

        // 6: align_en low for 5 cycles with a comma arriving
        send_comma();
        send_comma();
        send_comma();
        check("s6_locked", locked, 10'h001);
        c = next_comma();
        send_range(10'h000, 0, 9, 1'b1);
        send_range(c, 0, 4, 1'b0);
        align_en = 1'b0;
        det_cnt = 0; valid_cnt = 0;
        send_range(c, 5, 9, 1'b0);
        check("s6_dis_locked", locked,       10'h000);
        check("s6_dis_valid",  symbol_valid, 10'h000);
        check("s6_dis_det",    10'(det_cnt), 10'd1);
        check("s6_dis_nosym",  10'(valid_cnt), 10'd0);
        align_en = 1'b1;
        send_comma();
        check("s6_reacq", symbol_valid, 10'h001);
        send_comma();
        send_comma();
        check("s6_relock", locked, 10'h001);

        // Randomized traffic against the model
        for (int t = 0; t < 25; t++) begin
            send_random($urandom_range(0, 12));
            if ($urandom_range(0, 5) == 0) begin
                align_en = 1'b0;
                send_random($urandom_range(1, 3));
                align_en = 1'b1;
            end
            send_comma();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
